// File: rtl/multdiv_pkg.sv
// Shared types and helpers for the MultDiv unit: controller state encoding,
// Booth recoding ops, default datapath width and the 8-bit CLA slice.
package multdiv_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mult_state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10
  } booth_op_t;

  typedef struct packed {
    logic [7:0] sum;
    logic       gout;
    logic       pout;
  } cla8_t;

  // One 8-bit carry-lookahead slice: per-bit sums from lookahead carries,
  // plus group generate/propagate so slices can be chained.
  function automatic cla8_t cla8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    cla8_t      res;
    logic [7:0] g;
    logic [7:0] p;
    logic       c;
    logic       gg;
    g  = a & b;
    p  = a ^ b;
    c  = cin;
    gg = 1'b0;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      res.sum[i] = p[i] ^ c;
      c          = g[i] | (p[i] & c);
      gg         = g[i] | (p[i] & gg);
    end
    res.gout = gg;
    res.pout = &p;
    return res;
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// WIDTH+1 bit add/subtract: WIDTH/8 chained CLA slices plus a one-bit
// sign-extension full adder on bit WIDTH. Carry-out of the top bit is dropped.
module booth_addsub
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] sum
);

  logic [WIDTH:0] b_eff;
  logic           carry;
  cla8_t          slice;

  // Invert the second operand for subtraction and ripple group carries slice to slice.
  always_comb begin
    sum   = '0;
    slice = '0;
    if (sub) begin
      b_eff = ~b;
    end else begin
      b_eff = b;
    end
    carry = sub;
    for (int s = 0; s < WIDTH / 8; s++) begin
      slice          = cla8(a[s*8 +: 8], b_eff[s*8 +: 8], carry);
      sum[s*8 +: 8]  = slice.sum;
      carry          = slice.gout | (slice.pout & carry);
    end
    sum[WIDTH] = a[WIDTH] ^ b_eff[WIDTH] ^ carry;
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier controller: one add/sub plus arithmetic
// shift per cycle for WIDTH cycles, low WIDTH product bits and overflow flag.
module booth_mult_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  mult_state_t    state_r;
  logic [WIDTH:0] m_r;
  logic [WIDTH:0] acc_r;
  logic [WIDTH-1:0] q_r;
  logic           q_m1_r;
  logic [CW-1:0]  count_r;
  logic           exc_r;
  logic           rdy_r;
  logic           busy_r;

  booth_op_t      op_s;
  logic [WIDTH:0] addend_s;
  logic           sub_s;
  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] acc_next_s;
  logic [WIDTH-1:0] q_next_s;
  logic           exc_next_s;

  // Booth recoding of the current multiplier bit pair.
  always_comb begin
    case ({q_r[0], q_m1_r})
      2'b01:   op_s = OP_ADD;
      2'b10:   op_s = OP_SUB;
      default: op_s = OP_NOP;
    endcase
  end

  // A NOP adds zero so the accumulator passes through the shared adder unchanged.
  always_comb begin
    sub_s = (op_s == OP_SUB);
    if (op_s == OP_NOP) begin
      addend_s = '0;
    end else begin
      addend_s = m_r;
    end
  end

  booth_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a   (acc_r),
    .b   (addend_s),
    .sub (sub_s),
    .sum (sum_s)
  );

  // Arithmetic right shift of {sum,Q} and overflow check on the shifted result.
  always_comb begin
    acc_next_s = {sum_s[WIDTH], sum_s[WIDTH:1]};
    q_next_s   = {sum_s[0], q_r[WIDTH-1:1]};
    exc_next_s = (acc_next_s != {(WIDTH+1){q_next_s[WIDTH-1]}});
  end

  // Controller FSM, iteration counter and product shift registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      m_r     <= '0;
      acc_r   <= '0;
      q_r     <= '0;
      q_m1_r  <= 1'b0;
      count_r <= '0;
      exc_r   <= 1'b0;
      rdy_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          rdy_r <= 1'b0;
          if (ctrl_MULT) begin
            m_r     <= {data_operandA[WIDTH-1], data_operandA};
            acc_r   <= '0;
            q_r     <= data_operandB;
            q_m1_r  <= 1'b0;
            count_r <= '0;
            exc_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_r   <= acc_next_s;
          q_r     <= q_next_s;
          q_m1_r  <= q_r[0];
          count_r <= count_r + 1'b1;
          if (count_r == CW'(WIDTH - 1)) begin
            // Exception is taken from the final product so it is valid with the ready pulse.
            exc_r   <= exc_next_s;
            rdy_r   <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          rdy_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_result    = q_r;
  assign data_exception = exc_r;
  assign data_resultRDY = rdy_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: directed and random multiplies checked
// against a signed 64-bit arithmetic reference, with latency and pulse-width checks.
module tb_booth_mult_seq;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         ctrl_MULT = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         exc;
    int           start_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic rdy_prev = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference: full signed product; exception when it does not fit in W signed bits.
  function automatic void ref_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] r, output logic e);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    r = p[W-1:0];
    e = (p != longint'($signed(p[W-1:0])));
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: compare every ready pulse against the oldest outstanding expectation.
  always @(negedge clock) begin
    exp_t e;
    if (data_resultRDY) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rdy: resultRDY high at cycle %0d with nothing outstanding", cyc);
      end else begin
        e = sb.pop_front();
        check($sformatf("result(%h*%h)", e.a, e.b), data_result, e.res);
        check($sformatf("exception(%h*%h)", e.a, e.b), {31'd0, data_exception}, {31'd0, e.exc});
        // Ready appears in the 33rd cycle after the start edge, i.e. W edges later.
        check("latency", W'(cyc - e.start_cyc), W'(W));
      end
      check("rdy_width", {31'd0, rdy_prev}, 32'd0);
    end
    rdy_prev = data_resultRDY;
  end

  // Issue a start at the current negedge; returns one negedge later.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    ref_mult(a, b, e.res, e.exc);
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // Wait (bounded) until the ready pulse is visible at a negedge.
  task automatic wait_rdy();
    for (int i = 0; i < 100; i++) begin
      if (data_resultRDY) return;
      @(negedge clock);
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_rdy: no resultRDY within 100 cycles (got 0 expected 1)");
  endtask

  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b);
    issue(a, b);
    wait_rdy();
    @(negedge clock);
  endtask

  function automatic logic [W-1:0] rand_operand();
    int mode;
    mode = $urandom_range(0, 2);
    if (mode == 0) return W'($urandom);
    if (mode == 1) return W'(int'($urandom_range(0, 65535)) - 32768);
    return W'(1) << $urandom_range(0, W - 1);
  endfunction

  initial begin
    // Reset held two cycles.
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("reset_result", data_result, 32'd0);
    check("reset_exception", {31'd0, data_exception}, 32'd0);
    check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);

    // Directed cases.
    run_one(32'd7, 32'd6);
    run_one(32'hFFFF_FFFD, 32'd5);
    run_one(32'h8000_0000, 32'h8000_0000);
    run_one(32'h8000_0000, 32'hFFFF_FFFF);
    run_one(32'h0001_0000, 32'h0001_0000);
    run_one(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_one(32'd0, 32'hFFFF_FFFF);
    check("hold_result_idle", data_result, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);

    // Start strobe during RUN is ignored.
    issue(32'd1234, 32'hFFFF_FDC9);
    repeat (8) @(negedge clock);
    data_operandA = 32'd99;
    data_operandB = 32'd77;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    wait_rdy();
    @(negedge clock);

    // Reset mid-RUN aborts with no ready pulse.
    issue(32'd12345, 32'd678);
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    sb.delete();
    reset = 1'b0;
    check("abort_result", data_result, 32'd0);
    check("abort_exception", {31'd0, data_exception}, 32'd0);
    check("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clock);

    // Back-to-back: new start accepted in the DONE cycle.
    issue(32'hFFFF_FFF0, 32'd3);
    wait_rdy();
    issue(32'd2, 32'd3);
    wait_rdy();
    @(negedge clock);

    // Random multiplies, about half chained back-to-back.
    for (int k = 0; k < 24; k++) begin
      issue(rand_operand(), rand_operand());
      wait_rdy();
      if ($urandom_range(0, 1) == 0) begin
        @(negedge clock);
      end
    end
    wait_rdy();
    repeat (3) @(negedge clock);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
